axis_rr_arbiter: RTL and testbench

- Shares one AXI-Stream master port, toward the DAC sample path, between NUM_SRC AXI-Stream slave sources.
- Arbitration is round-robin and packet-locked: a granted source keeps the output until its tlast beat is accepted.
- The winning source index is driven on m_tid so downstream logic can demultiplex.
- The block sits between the per-channel sample generators and the single DAC-side stream.

---
 rtl/axis_arb_pkg.sv | 28 ++
 rtl/rr_priority_picker.sv | 32 +++
 rtl/axis_rr_arbiter.sv | 117 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  // Arbiter control states: IDLE picks a winner, BUSY forwards its packet.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Largest source count the arbiter supports; sizes the index helper.
  localparam int MAX_SRC = 16;

  // Width of a source index for a given source count (at least one bit).
  function automatic int src_idx_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Convert a one-hot vector into the index of its set bit; all-zero maps to 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first requester at or above ptr, wrapping to 0.
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic               found
);

  // Walk offsets 0..NUM_SRC-1 from ptr; the first requester seen wins.
  always_comb begin
    int idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!found && (j == idx) && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXI-Stream sources onto
// the single DAC-side stream. One bubble cycle per packet is spent arbitrating;
// the winner then owns the output until its tlast beat is accepted.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 4
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic [NUM_SRC-1:0]             s_tvalid,
  output logic [NUM_SRC-1:0]             s_tready,
  input  logic [NUM_SRC-1:0]             s_tlast,
  input  logic [NUM_SRC*DATA_SIZE-1:0]   s_tdata,
  input  logic [NUM_SRC*DATA_SIZE/8-1:0] s_tkeep,
  input  logic [NUM_SRC*DATA_SIZE/8-1:0] s_tstrb,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic [DATA_SIZE-1:0]           m_tdata,
  output logic [DATA_SIZE/8-1:0]         m_tkeep,
  output logic [DATA_SIZE/8-1:0]         m_tstrb,
  output logic [ID_SIZE-1:0]             m_tid,
  output logic                           busy,
  output logic [NUM_SRC-1:0]             grant
);

  localparam int SRC_IDX_W = src_idx_w(NUM_SRC);
  localparam int KEEP_W    = DATA_SIZE / 8;

  arb_state_e             state_q;
  logic [NUM_SRC-1:0]     grant_q;
  logic [SRC_IDX_W-1:0]   rr_ptr_q;
  logic                   busy_q;

  logic [SRC_IDX_W-1:0]   rr_ptr_d;
  logic [NUM_SRC-1:0]     pick_gnt;
  logic                   pick_found;
  logic [3:0]             g_idx;
  logic                   pkt_end;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (SRC_IDX_W)
  ) u_picker (
    .req   (s_tvalid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  // Granted index and the pointer that favours the next source after it.
  always_comb begin
    g_idx    = onehot_to_idx(MAX_SRC'(grant_q));
    rr_ptr_d = (int'(g_idx) >= NUM_SRC - 1) ? '0 : SRC_IDX_W'(int'(g_idx) + 1);
  end

  // Steer the granted source onto the master port; a zero grant forces all zeros.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tstrb  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        m_tvalid = s_tvalid[i];
        m_tlast  = s_tlast[i];
        m_tdata  = s_tdata[i*DATA_SIZE +: DATA_SIZE];
        m_tkeep  = s_tkeep[i*KEEP_W +: KEEP_W];
        m_tstrb  = s_tstrb[i*KEEP_W +: KEEP_W];
      end
    end
  end

  assign pkt_end  = m_tvalid & m_tready & m_tlast;
  assign s_tready = grant_q & {NUM_SRC{m_tready}};
  assign m_tid    = ID_SIZE'(g_idx);
  assign busy     = busy_q;
  assign grant    = grant_q;

  // Arbitration FSM: lock a winner in IDLE, release it on its accepted tlast.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_gnt;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: queue-driven sources, a packet-level reference
// model checked every cycle, and literal expectations per directed scenario.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = 4;

  logic            aclk;
  logic            areset_n;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep, s_tstrb;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep, m_tstrb;
  logic [IW-1:0]   m_tid;
  logic            busy;
  logic [N-1:0]    grant;

  axis_rr_arbiter #(.NUM_SRC(N), .DATA_SIZE(DW), .ID_SIZE(IW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tstrb(m_tstrb),
    .m_tid(m_tid), .busy(busy), .grant(grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] d; logic last; } beat_t;
  typedef struct { int cyc; logic [DW-1:0] d; logic [IW-1:0] tid; logic last; } obs_t;

  beat_t  srcq [N][$];
  logic   rdyq [$];
  obs_t   obs  [$];
  int     gap [N];
  int     gap_after [N];
  int     pops [N];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     busy_cnt = 0;
  bit     chk_en = 1'b0;
  int     lock_m = -1;
  int     ptr_m = 0;
  logic [N-1:0] hs = '0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: compare DUT to packet-level rules, then advance the model.
  always @(negedge aclk) begin : cmp
    logic ev, el, eb;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek, es;
    logic [N-1:0]  er, eg;
    logic [IW-1:0] et;
    int s;
    cyc++;
    ev = 1'b0; el = 1'b0; eb = 1'b0; ed = '0; ek = '0; es = '0;
    er = '0; eg = '0; et = '0; s = 0;
    if (chk_en) begin
      if (areset_n && lock_m >= 0) begin
        ev = s_tvalid[lock_m];
        el = s_tlast[lock_m];
        ed = s_tdata[lock_m*DW +: DW];
        ek = s_tkeep[lock_m*KW +: KW];
        es = s_tstrb[lock_m*KW +: KW];
        er[lock_m] = m_tready;
        eg[lock_m] = 1'b1;
        eb = 1'b1;
        et = IW'(lock_m);
      end
      chk("m_tvalid", 64'(m_tvalid), 64'(ev));
      chk("m_tlast",  64'(m_tlast),  64'(el));
      chk("m_tdata",  64'(m_tdata),  64'(ed));
      chk("m_tkeep",  64'(m_tkeep),  64'(ek));
      chk("m_tstrb",  64'(m_tstrb),  64'(es));
      chk("m_tid",    64'(m_tid),    64'(et));
      chk("s_tready", 64'(s_tready), 64'(er));
      chk("grant",    64'(grant),    64'(eg));
      chk("busy",     64'(busy),     64'(eb));
      if (busy === 1'b1) busy_cnt++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1)
        obs.push_back('{cyc, m_tdata, m_tid, m_tlast});
      if (!areset_n) begin
        lock_m = -1;
        ptr_m  = 0;
        hs     = '0;
      end else begin
        hs = s_tvalid & er;
        if (lock_m < 0) begin
          for (int k = 0; k < N; k++) begin
            s = (ptr_m + k) % N;
            if (lock_m < 0 && s_tvalid[s]) lock_m = s;
          end
        end else if (ev && m_tready && el) begin
          ptr_m  = (lock_m + 1) % N;
          lock_m = -1;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d;
      logic l;
      d = 32'hDEAD_0000 | 32'(i);
      l = 1'b0;
      if (srcq[i].size() > 0) begin
        d = srcq[i][0].d;
        l = srcq[i][0].last;
      end
      s_tvalid[i] = (srcq[i].size() > 0) && (gap[i] == 0);
      s_tlast[i]  = l;
      s_tdata[i*DW +: DW] = d;
      s_tkeep[i*KW +: KW] = d[3:0] ^ 4'hF;
      s_tstrb[i*KW +: KW] = d[7:4];
    end
    m_tready = (rdyq.size() > 0) ? rdyq[0] : 1'b1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      gap[i] = 0;
      gap_after[i] = -1;
      pops[i] = 0;
    end
    rdyq.delete();
  endtask

  task automatic step();
    @(posedge aclk);
    for (int i = 0; i < N; i++) begin
      if (gap[i] > 0) gap[i]--;
      if (hs[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        pops[i]++;
        if (pops[i] == gap_after[i]) gap[i] = 3;
      end
    end
    if (rdyq.size() > 0) void'(rdyq.pop_front());
    #1 drive();
  endtask

  task automatic push_pkt(input int src, input int nb, input logic [DW-1:0] base);
    for (int b = 0; b < nb; b++) srcq[src].push_back('{base + DW'(b), (b == nb - 1)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input int budget, input string nm);
    int n;
    n = 0;
    while (!(all_empty() && lock_m < 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want drained", nm, n);
    end
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #2 areset_n = 1'b0;
    clear_src();
    hs = '0;
    drive();
    @(negedge aclk);
    #2 areset_n = 1'b1;
    step();
  endtask

  task automatic chk_beat(input string nm, input int k, input int tid, input logic last,
                          input logic [DW-1:0] d);
    if (k >= obs.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: beat %0d missing, got %0d beats", nm, k, obs.size());
    end else begin
      chk(nm, {27'd0, obs[k].tid, obs[k].last, obs[k].d}, {27'd0, 4'(tid), last, d});
    end
  endtask

  task automatic chk_cyc(input string nm, input int k, input int base, input int off);
    if (k >= obs.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: beat %0d missing, got %0d beats", nm, k, obs.size());
    end else begin
      chk(nm, 64'(obs[k].cyc - base), 64'(off));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    int t2_tid [10];
    logic [DW-1:0] t2_d [10];
    t2_tid = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    t2_d   = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0010, 32'hB000_0011,
               32'hB000_0020, 32'hB000_0021, 32'hB000_0030, 32'hB000_0031,
               32'hB000_0100, 32'hB000_0101};
    areset_n = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tstrb = '0;
    m_tready = 1'b1;
    clear_src();
    drive();
    #1 areset_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge aclk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_grant",    64'(grant),    64'd0);
    chk("rst_m_tid",    64'(m_tid),    64'd0);
    #2 areset_n = 1'b1;
    step();

    // Single source 0, 3-beat packet
    obs.delete(); busy_cnt = 0;
    push_pkt(0, 3, 32'hA0);
    t0 = cyc;
    drive();
    run(50, "t1");
    chk_beat("t1_b0", 0, 0, 1'b0, 32'hA0);
    chk_beat("t1_b1", 1, 0, 1'b0, 32'hA1);
    chk_beat("t1_b2", 2, 0, 1'b1, 32'hA2);
    chk_cyc("t1_bubble", 0, t0, 2);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd3);
    chk("t1_beats", 64'(obs.size()), 64'd3);

    // All four sources from reset, source 0 has a second packet
    do_reset();
    obs.delete();
    for (int i = 0; i < N; i++) push_pkt(i, 2, 32'hB000_0000 + 32'(16 * i));
    push_pkt(0, 2, 32'hB000_0100);
    t0 = cyc;
    drive();
    run(100, "t2");
    for (int k = 0; k < 10; k++) chk_beat("t2_order", k, t2_tid[k], (k % 2) == 1, t2_d[k]);
    for (int p = 0; p < 5; p++) chk_cyc("t2_idle_gap", 2 * p, t0, 2 + 3 * p);

    // Source 2 with m_tready toggling during a 4-beat packet
    obs.delete(); busy_cnt = 0;
    push_pkt(2, 4, 32'hC0);
    rdyq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    drive();
    run(50, "t3");
    for (int k = 0; k < 4; k++) chk_beat("t3_beat", k, 2, k == 3, 32'hC0 + DW'(k));
    chk("t3_busy_cycles", 64'(busy_cnt), 64'd7);
    if (obs.size() >= 4) chk("t3_span", 64'(obs[3].cyc - obs[0].cyc), 64'd6);

    // Source 1 valid gap mid-packet while source 3 waits
    do_reset();
    obs.delete();
    push_pkt(1, 4, 32'hD0);
    push_pkt(3, 1, 32'hE0);
    gap_after[1] = 2;
    drive();
    run(80, "t4");
    for (int k = 0; k < 4; k++) chk_beat("t4_hold", k, 1, k == 3, 32'hD0 + DW'(k));
    chk_beat("t4_next", 4, 3, 1'b1, 32'hE0);
    if (obs.size() >= 5) begin
      chk("t4_gap", 64'(obs[2].cyc - obs[1].cyc), 64'd4);
      chk("t4_handover", 64'(obs[4].cyc - obs[3].cyc), 64'd2);
    end

    // Asynchronous reset mid-packet, then rr_ptr must restart at 0
    obs.delete();
    push_pkt(1, 1, 32'hF0);
    drive();
    run(30, "t5a");
    push_pkt(2, 4, 32'hF8);
    drive();
    n = 0;
    while (obs.size() < 3 && n < 40) begin
      step();
      n++;
    end
    chk("t5_pre_busy", 64'(busy), 64'd1);
    #2 areset_n = 1'b0;
    #1;
    chk("t5_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_rst_s_tready", 64'(s_tready), 64'd0);
    chk("t5_rst_busy",     64'(busy),     64'd0);
    chk("t5_rst_m_tdata",  64'(m_tdata),  64'd0);
    clear_src();
    hs = '0;
    drive();
    @(negedge aclk);
    #2 areset_n = 1'b1;
    step();
    obs.delete();
    push_pkt(0, 1, 32'h11);
    push_pkt(2, 1, 32'h22);
    drive();
    run(30, "t5b");
    chk_beat("t5_first", 0, 0, 1'b1, 32'h11);
    chk_beat("t5_second", 1, 2, 1'b1, 32'h22);

    // rr_ptr wrap: after source 3, source 0 beats source 3
    push_pkt(3, 1, 32'h33);
    drive();
    run(30, "t6a");
    obs.delete();
    push_pkt(0, 1, 32'h44);
    push_pkt(3, 1, 32'h55);
    drive();
    run(30, "t6b");
    chk_beat("t6_first", 0, 0, 1'b1, 32'h44);
    chk_beat("t6_second", 1, 3, 1'b1, 32'h55);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
